// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-RAM arbiter.
//   arb_state_e : arbiter occupancy (IDLE / BUSY)
//   NREQ_MAX    : largest supported requester count
//   LOCK_CNT_W  : width of the consecutive-lock counter
//   idx_width() : bits needed to hold a requester index
package mem_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int NREQ_MAX   = 8;
    localparam int LOCK_CNT_W = 4;

    // At least one bit even for two requesters.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational one-hot selector.
//   req    : request vector
//   start  : index where the search begins; wraps at NREQ
//   excl   : requesters that may not win this round
//   onehot : winning requester (all zero when none)
//   idx    : index of the winner
//   found  : a winner exists
module arb_pick #(
    parameter int NREQ = 3,
    parameter int IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] start,
    input  logic [NREQ-1:0] excl,
    output logic [NREQ-1:0] onehot,
    output logic [IDXW-1:0] idx,
    output logic            found
);

    // Walk the requesters from start, first eligible one wins.
    always_comb begin
        int  c;
        logic hit;
        c      = 0;
        hit    = 1'b0;
        onehot = {NREQ{1'b0}};
        idx    = {IDXW{1'b0}};
        found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            c         = (int'(start) + k) % NREQ;
            hit       = !found && req[c] && !excl[c];
            onehot[c] = hit;
            idx       = hit ? IDXW'(c) : idx;
            found     = found | hit;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port data-RAM arbiter for NREQ requesters (index 0 = CPU data port).
// Owner is registered each cycle; RAM ports are muxed combinationally from
// the owner's current request inputs; read data returns one cycle later with
// RVALID tagged to the requester. A locked owner may keep the grant for at
// most MAX_LOCK consecutive cycles.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req/lock/req_we             per-requester request, lock, write flag
//   req_addr/req_wdata          packed per-requester address / write data
//   gnt, rvalid                 one-hot grant and read-return tag
//   rdata                       read data broadcast to all requesters
//   ram_we/ram_addr/ram_wd      RAM command
//   ram_rd                      RAM read data (one cycle after address)
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// without it the lowest requester index wins.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NREQ     = 3,
    parameter int MAX_LOCK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ-1:0]       req_we,
    input  logic [NREQ*WIDTH-1:0] req_addr,
    input  logic [NREQ*WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rvalid,
    output logic [WIDTH-1:0]      rdata,
    output logic                  ram_we,
    output logic [WIDTH-1:0]      ram_addr,
    output logic [WIDTH-1:0]      ram_wd,
    input  logic [WIDTH-1:0]      ram_rd
);

    localparam int                    IDXW      = idx_width(NREQ);
    localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(MAX_LOCK - 1);
    localparam logic [NREQ-1:0]       ONE_HOT0  = NREQ'(1);

    arb_state_e            state_r;
    logic [IDXW-1:0]       owner_r;
    logic [LOCK_CNT_W-1:0] lock_cnt_r;
    logic [NREQ-1:0]       gnt_r;
    logic [NREQ-1:0]       rvalid_r;

    logic                  busy_s;
    logic                  own_lock_s;
    logic                  keep_s;
    logic                  limited_s;
    logic                  others_s;
    logic [NREQ-1:0]       owner_oh_s;
    logic [NREQ-1:0]       excl_s;
    logic [IDXW-1:0]       start_s;
    logic [NREQ-1:0]       pick_oh_s;
    logic [IDXW-1:0]       pick_idx_s;
    logic                  pick_found_s;

    assign busy_s     = (state_r == BUSY);
    assign owner_oh_s = ONE_HOT0 << owner_r;
    // Owner wants to stay; it may only while the run is below the limit.
    assign own_lock_s = busy_s && lock[owner_r] && req[owner_r];
    assign keep_s     = own_lock_s && (lock_cnt_r < LOCK_LAST);
    assign limited_s  = own_lock_s && (lock_cnt_r >= LOCK_LAST);
    assign others_s   = |(req & ~owner_oh_s);
    // A lock-limited owner sits out one round when anybody else is waiting.
    assign excl_s     = (limited_s && others_s) ? owner_oh_s : {NREQ{1'b0}};

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [IDXW-1:0] ptr_r;

    assign start_s = (ptr_r == IDXW'(NREQ - 1)) ? {IDXW{1'b0}} : ptr_r + IDXW'(1);

    // Round-robin pointer follows every fresh (non-lock) grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= {IDXW{1'b0}};
        end else if (!keep_s && pick_found_s) begin
            ptr_r <= pick_idx_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    assign start_s = {IDXW{1'b0}};
`endif

    arb_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req    (req),
        .start  (start_s),
        .excl   (excl_s),
        .onehot (pick_oh_s),
        .idx    (pick_idx_s),
        .found  (pick_found_s)
    );

    // Owner, lock run length and grant register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            owner_r    <= {IDXW{1'b0}};
            lock_cnt_r <= {LOCK_CNT_W{1'b0}};
            gnt_r      <= {NREQ{1'b0}};
        end else if (keep_s) begin
            state_r    <= BUSY;
            owner_r    <= owner_r;
            lock_cnt_r <= lock_cnt_r + LOCK_CNT_W'(1);
            gnt_r      <= owner_oh_s;
        end else if (pick_found_s) begin
            state_r    <= BUSY;
            owner_r    <= pick_idx_s;
            lock_cnt_r <= {LOCK_CNT_W{1'b0}};
            gnt_r      <= pick_oh_s;
        end else begin
            state_r    <= IDLE;
            owner_r    <= owner_r;
            lock_cnt_r <= {LOCK_CNT_W{1'b0}};
            gnt_r      <= {NREQ{1'b0}};
        end
    end

    // Tag the next cycle's RAM read data with the requester that issued the read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_r <= {NREQ{1'b0}};
        end else if (busy_s && !req_we[owner_r]) begin
            rvalid_r <= owner_oh_s;
        end else begin
            rvalid_r <= {NREQ{1'b0}};
        end
    end

    // RAM command comes straight from the registered owner's live inputs.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = {WIDTH{1'b0}};
        ram_wd   = {WIDTH{1'b0}};
        if (busy_s) begin
            ram_we   = req_we[owner_r];
            ram_addr = req_addr[int'(owner_r)*WIDTH +: WIDTH];
            ram_wd   = req_wdata[int'(owner_r)*WIDTH +: WIDTH];
        end else begin
            ram_we   = 1'b0;
        end
    end

    // RAM data is only valid in the return cycle, so it is gated rather than registered.
    always_comb begin
        rdata = {WIDTH{1'b0}};
        if (|rvalid_r) begin
            rdata = ram_rd;
        end else begin
            rdata = {WIDTH{1'b0}};
        end
    end

    assign gnt    = gnt_r;
    assign rvalid = rvalid_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, all compared against a behavioural model of the arbitration rules.
module tb_mem_arbiter;

    localparam int W  = 32;
    localparam int N  = 3;
    localparam int ML = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    d_req, d_lock, d_we;
    logic [N*W-1:0]  req_addr, req_wdata;
    logic [N-1:0]    gnt, rvalid;
    logic [W-1:0]    rdata, ram_addr, ram_wd, ram_rd;
    logic            ram_we;

    logic [31:0] a_addr [N];
    logic [31:0] a_wd   [N];

    logic [31:0] ram_mem [0:63] = '{4: 32'hDEADBEEF, default: 32'hC0DE_0000};
    logic [31:0] ref_mem [0:63] = '{4: 32'hDEADBEEF, default: 32'hC0DE_0000};

    int total = 0;
    int bad   = 0;

    // model state
    int          m_owner, m_run, m_ptr, m_rv;
    logic [31:0] m_rv_data;

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(W), .NREQ(N), .MAX_LOCK(ML)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (d_req),
        .lock      (d_lock),
        .req_we    (d_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wd    (ram_wd),
        .ram_rd    (ram_rd)
    );

    // synchronous single-port RAM
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr[7:2]] <= ram_wd;
        ram_rd <= ram_mem[ram_addr[7:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_run = 0; m_ptr = 0; m_rv = -1; m_rv_data = 32'h0;
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req_addr[i*W +: W]  = a_addr[i];
            req_wdata[i*W +: W] = a_wd[i];
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0] eg, erv;
        logic         ew;
        logic [31:0]  ea, ed, er;
        eg = '0; erv = '0; ew = 1'b0; ea = 32'h0; ed = 32'h0; er = 32'h0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            ew = d_we[m_owner];
            ea = a_addr[m_owner];
            ed = a_wd[m_owner];
        end
        if (m_rv >= 0) begin
            erv[m_rv] = 1'b1;
            er = m_rv_data;
        end
        chk({tag, ".gnt"},    32'(gnt),    32'(eg));
        chk({tag, ".rvalid"}, 32'(rvalid), 32'(erv));
        chk({tag, ".rdata"},  rdata,       er);
        chk({tag, ".ram_we"}, 32'(ram_we), 32'(ew));
        chk({tag, ".ram_addr"}, ram_addr,  ea);
        chk({tag, ".ram_wd"},   ram_wd,    ed);
    endtask

    // apply the arbitration rules to this cycle's inputs, then move to the next cycle
    task automatic advance();
        int  nxt, start, j;
        bit  limited, others;
        m_rv = -1;
        if (m_owner >= 0) begin
            if (d_we[m_owner]) ref_mem[a_addr[m_owner][7:2]] = a_wd[m_owner];
            else begin
                m_rv      = m_owner;
                m_rv_data = ref_mem[a_addr[m_owner][7:2]];
            end
        end
        if (m_owner >= 0 && d_lock[m_owner] && d_req[m_owner] && m_run < ML - 1) begin
            m_run++;
        end else begin
            limited = (m_owner >= 0) && d_lock[m_owner] && d_req[m_owner];
            others  = 1'b0;
            for (int i = 0; i < N; i++) if (i != m_owner && d_req[i]) others = 1'b1;
            start = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            start = (m_ptr + 1) % N;
`endif
            nxt = -1;
            for (int k = 0; k < N; k++) begin
                j = (start + k) % N;
                if (nxt < 0 && d_req[j] && !(limited && others && j == m_owner)) nxt = j;
            end
            m_owner = nxt;
            m_run   = 0;
            if (nxt >= 0) m_ptr = nxt;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag);
        apply();
        check_all(tag);
        advance();
    endtask

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N-1:0] w);
        d_req = r; d_lock = l; d_we = w;
    endtask

    logic [N-1:0] lk_req  [7] = '{3'b100, 3'b101, 3'b101, 3'b101, 3'b101, 3'b100, 3'b000};
    logic [N-1:0] lk_lock [7] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000};
    logic [N-1:0] lk_gnt  [7] = '{3'b000, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b100};

    initial begin
        rst_n = 1'b0;
        drive(3'b000, 3'b000, 3'b000);
        for (int i = 0; i < N; i++) begin
            a_addr[i] = 32'h0; a_wd[i] = 32'h0;
        end
        model_reset();
        apply();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // idle
        for (int t = 0; t < 10; t++) begin
            apply();
            check_all("idle");
            chk("idle.lock_cnt", 32'(dut.lock_cnt_r), 32'h0);
            advance();
        end

        // single read of 0x10 by requester 1
        a_addr[1] = 32'h10;
        drive(3'b010, 3'b000, 3'b000);
        cyc("rd.req");
        drive(3'b000, 3'b000, 3'b000);
        apply();
        chk("rd.gnt", 32'(gnt), 32'h2);
        cyc("rd.gntcyc");
        chk("rd.rvalid", 32'(rvalid), 32'h2);
        chk("rd.rdata", rdata, 32'hDEADBEEF);
        cyc("rd.ret");

        // contention, all requesters, no lock
        for (int i = 0; i < N; i++) begin
            a_addr[i] = 32'(i * 8 + 64); a_wd[i] = 32'(i + 1);
        end
        drive(3'b111, 3'b000, 3'b000);
        for (int t = 0; t < 6; t++) cyc("cont");
        drive(3'b000, 3'b000, 3'b000);
        cyc("cont.end");
        cyc("cont.idle");

        // lock limit on requester 2 with requester 0 waiting
        for (int t = 0; t < 7; t++) begin
            drive(lk_req[t], lk_lock[t], 3'b000);
            apply();
            chk("lock.gnt", 32'(gnt), 32'(lk_gnt[t]));
            check_all("lock");
            advance();
        end
        drive(3'b000, 3'b000, 3'b000);
        cyc("lock.end");
        cyc("lock.idle");

        // write 0x55AA to 0x20 then read it back via requester 0
        a_addr[0] = 32'h20; a_wd[0] = 32'h55AA;
        drive(3'b001, 3'b000, 3'b001);
        cyc("wr.req");
        drive(3'b000, 3'b000, 3'b001);
        apply();
        chk("wr.ram_we", 32'(ram_we), 32'h1);
        cyc("wr.gnt");
        drive(3'b001, 3'b000, 3'b000);
        apply();
        chk("wr.no_rvalid", 32'(rvalid), 32'h0);
        cyc("rb.req");
        drive(3'b000, 3'b000, 3'b000);
        apply();
        chk("rb.ram_we", 32'(ram_we), 32'h0);
        cyc("rb.gnt");
        chk("rb.rvalid", 32'(rvalid), 32'h1);
        chk("rb.rdata", rdata, 32'h55AA);
        cyc("rb.ret");

        // reset in the cycle after a read grant
        a_addr[1] = 32'h10;
        drive(3'b010, 3'b000, 3'b000);
        cyc("rst.req");
        drive(3'b000, 3'b000, 3'b000);
        cyc("rst.gnt");
        rst_n = 1'b0;
        #1;
        chk("rst.gnt0", 32'(gnt), 32'h0);
        chk("rst.rvalid0", 32'(rvalid), 32'h0);
        chk("rst.ram_we0", 32'(ram_we), 32'h0);
        chk("rst.rdata0", rdata, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int t = 0; t < 3; t++) cyc("rst.after");

        // random traffic
        for (int t = 0; t < 400; t++) begin
            drive(N'($urandom), N'($urandom_range(0, 3) == 0 ? $urandom : 0), N'($urandom));
            for (int i = 0; i < N; i++) begin
                a_addr[i] = 32'($urandom_range(0, 15)) << 2;
                a_wd[i]   = $urandom;
            end
            cyc("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
